// File: rtl/timer_pkg.sv
// Shared constants and types for the memory-mapped down-counting timer.
package timer_pkg;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_PRESET = 2'd1;
  localparam logic [1:0] A_COUNT  = 2'd2;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_MODE = 1;
  localparam int CTRL_IM   = 3;

  localparam logic [1:0] MODE_ONESHOT    = 2'b00;
  localparam logic [1:0] MODE_AUTORELOAD = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  // Field order mirrors the CTRL bit positions so the struct maps onto wdata[3:0].
  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } ctrl_t;

endpackage

// File: rtl/timer_dev_if.sv
// Register bus between the system bridge and the timer.
interface timer_dev_if #(parameter int DW = 32);
  logic [1:0]    addr;
  logic          we;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          irq;

  modport master (output addr, we, wdata, input rdata, irq);
  modport slave  (input addr, we, wdata, output rdata, irq);
endinterface

// File: rtl/timer_dev.sv
// 32-bit down-counting timer: one-shot with held irq, or auto-reload with a
// one-cycle irq pulse per period.
module timer_dev
  import timer_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  timer_dev_if.slave bus
);

  ctrl_t         ctrl;
  logic [DW-1:0] preset;
  logic [DW-1:0] count;
  logic          pending;
  state_e        state, state_nxt;

  logic wr_ctrl, wr_preset, auto_mode, cnt_done;
  logic load_cnt, dec_cnt, zero_cnt, set_pend, clr_pend, clr_en;

  assign wr_ctrl   = bus.we && (bus.addr == A_CTRL);
  assign wr_preset = bus.we && (bus.addr == A_PRESET);
  // Reserved modes (1x) fall back to one-shot.
  assign auto_mode = (ctrl.mode == MODE_AUTORELOAD);
  assign cnt_done  = (count <= DW'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (ctrl.en) state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = ST_CNT;
      ST_CNT: begin
        if (!ctrl.en)     state_nxt = ST_IDLE;
        else if (cnt_done) state_nxt = ST_INT;
      end
      ST_INT:  state_nxt = auto_mode ? ST_LOAD : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    load_cnt = (state == ST_LOAD);
    dec_cnt  = (state == ST_CNT) && ctrl.en && !cnt_done;
    zero_cnt = (state == ST_CNT) && ctrl.en && cnt_done;
    set_pend = zero_cnt;
    clr_pend = (state == ST_INT) && auto_mode;
    clr_en   = (state == ST_INT) && !auto_mode;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl    <= '0;
      preset  <= '0;
      count   <= '0;
      pending <= 1'b0;
    end else begin
      // A bus write to CTRL overrides the FSM's own EN clear.
      if (wr_ctrl)     ctrl <= ctrl_t'(bus.wdata[3:0]);
      else if (clr_en) ctrl.en <= 1'b0;

      if (wr_preset) preset <= bus.wdata;

      if (load_cnt)      count <= preset;
      else if (dec_cnt)  count <= count - DW'(1);
      else if (zero_cnt) count <= '0;

      // A new expiry wins over a coincident CTRL write, so setting IM in the
      // expiry cycle still raises irq.
      if (set_pend)                 pending <= 1'b1;
      else if (wr_ctrl || clr_pend) pending <= 1'b0;
    end
  end

  assign bus.irq = pending & ctrl.im;

  always_comb begin
    bus.rdata = '0;
    unique case (bus.addr)
      A_CTRL:   bus.rdata = {{(DW-4){1'b0}}, ctrl};
      A_PRESET: bus.rdata = preset;
      A_COUNT:  bus.rdata = count;
      default:  bus.rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_timer_dev.sv
// Scoreboard bench for timer_dev: stimulus queues expected reads, a negedge
// monitor pops and compares them against the live bus.
module tb_timer_dev;
  import timer_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  timer_dev_if #(.DW(32)) bus ();
  timer_dev #(.DW(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [31:0] d;
    logic        irq;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic chk     = 1'b0;

  always @(negedge clk) begin
    if (chk) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard: read sampled with nothing expected");
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.rdata !== mon_e.d || bus.irq !== mon_e.irq) begin
          n_fail++;
          $display("FAIL %s: got rdata=%h irq=%b, want rdata=%h irq=%b",
                   mon_e.name, bus.rdata, bus.irq, mon_e.d, mon_e.irq);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.addr = a; bus.we = 1'b1; bus.wdata = d;
    cyc();
    bus.we = 1'b0;
  endtask

  // Expects the state left by the previous edge, then consumes one edge.
  task automatic rd(input logic [1:0] a, input logic [31:0] d, input logic irq, input string name);
    bus.addr = a;
    exp_q.push_back('{d, irq, name});
    chk = 1'b1;
    cyc();
    chk = 1'b0;
  endtask

  // Reference timing, k = edges since the enabling CTRL write (k >= 2).
  function automatic int eff(input int n);
    return (n < 1) ? 1 : n;
  endfunction

  function automatic logic [31:0] os_count(input int n, input int k);
    if (k <= eff(n) + 1) return 32'(n - (k - 2));
    return 32'd0;
  endfunction

  function automatic logic os_irq(input int n, input int k);
    return k >= eff(n) + 2;
  endfunction

  function automatic logic [31:0] ar_count(input int n, input int k);
    int r;
    r = (k - 1) % (eff(n) + 2);
    if (r == 0 || r == eff(n) + 1) return 32'd0;
    return 32'(n - (r - 1));
  endfunction

  function automatic logic ar_irq(input int n, input int k);
    return ((k - 1) % (eff(n) + 2)) == eff(n) + 1;
  endfunction

  task automatic run_oneshot(input int n, input logic [31:0] cw, input string tag);
    logic im;
    im = cw[3];
    wr(A_PRESET, 32'(n));
    wr(A_CTRL, cw);
    rd(A_CTRL, {28'd0, cw[3:0]}, 1'b0, {tag, "_ctrl_k0"});
    rd(A_CTRL, {28'd0, cw[3:0]}, 1'b0, {tag, "_ctrl_k1"});
    for (int k = 2; k <= eff(n) + 4; k++)
      rd(A_COUNT, os_count(n, k), im & os_irq(n, k), {tag, "_cnt"});
    rd(A_CTRL, {28'd0, cw[3:1], 1'b0}, im, {tag, "_ctrl_done"});
    wr(A_CTRL, cw & 32'h8);
    rd(A_CTRL, cw & 32'h8, 1'b0, {tag, "_ack"});
    idle(2);
  endtask

  task automatic run_auto(input int n, input logic im, input int periods, input string tag);
    wr(A_PRESET, 32'(n));
    wr(A_CTRL, {28'd0, im, MODE_AUTORELOAD, 1'b1});
    idle(2);
    for (int k = 2; k <= periods * (eff(n) + 2); k++)
      rd(A_COUNT, ar_count(n, k), im & ar_irq(n, k), {tag, "_cnt"});
    wr(A_CTRL, 32'h0);
    idle(3);
  endtask

  initial begin
    int n;
    int m;
    logic [1:0] md;
    logic im;
    rst_n = 1'b0; bus.addr = A_CTRL; bus.we = 1'b1; bus.wdata = 32'hFFFF_FFFF;
    idle(2);
    rst_n = 1'b1; bus.we = 1'b0;
    rd(A_CTRL,   32'd0, 1'b0, "reset_ctrl");
    rd(A_PRESET, 32'd0, 1'b0, "reset_preset");
    rd(A_COUNT,  32'd0, 1'b0, "reset_count");

    run_oneshot(5, 32'h9, "oneshot5");
    run_auto(3, 1'b1, 4, "auto3");
    run_auto(3, 1'b0, 2, "auto3_masked");

    // Clear EN when COUNT reaches 6, then re-enable from PRESET.
    wr(A_PRESET, 32'd10);
    wr(A_CTRL, 32'h9);
    idle(2);
    for (int k = 2; k <= 4; k++) rd(A_COUNT, os_count(10, k), 1'b0, "dis_cnt");
    wr(A_CTRL, 32'h8);
    repeat (5) rd(A_COUNT, 32'd6, 1'b0, "dis_frozen");
    wr(A_CTRL, 32'h9);
    idle(2);
    rd(A_COUNT, 32'd10, 1'b0, "reen_reload");
    rd(A_COUNT, 32'd9, 1'b0, "reen_dec");
    wr(A_CTRL, 32'h0);
    idle(3);

    run_oneshot(0, 32'h9, "preset0");

    // PRESET change mid-count only applies at the following reload.
    wr(A_PRESET, 32'd3);
    wr(A_CTRL, 32'hB);
    idle(2);
    rd(A_COUNT, ar_count(3, 2), 1'b0, "pchg_old");
    wr(A_PRESET, 32'd7);
    for (int k = 4; k <= 5; k++) rd(A_COUNT, ar_count(3, k), ar_irq(3, k), "pchg_old");
    for (int k = 1; k <= 18; k++) rd(A_COUNT, ar_count(7, k), ar_irq(7, k), "pchg_new");
    wr(A_CTRL, 32'h0);
    idle(3);

    run_oneshot(4, 32'hFFFF_FFFF, "ctrl_ones");
    wr(A_COUNT, 32'h1234_5678);
    rd(A_COUNT, 32'd0, 1'b0, "count_wr_ignored");
    wr(2'd3, 32'hDEAD_BEEF);
    rd(2'd3, 32'd0, 1'b0, "addr3_zero");

    for (int i = 0; i < 6; i++) begin
      n  = $urandom_range(0, 15);
      m  = $urandom_range(0, 2);
      md = (m == 0) ? 2'b00 : (m == 1) ? 2'b10 : 2'b11;
      im = 1'($urandom_range(0, 1));
      run_oneshot(n, ($urandom() & 32'hFFFF_FFF0) | {28'd0, im, md, 1'b1}, "rand_oneshot");
    end
    for (int i = 0; i < 3; i++) begin
      n  = $urandom_range(0, 5);
      im = 1'($urandom_range(0, 1));
      run_auto(n, im, 3, "rand_auto");
    end

    // Reset while a one-shot interrupt is held.
    wr(A_PRESET, 32'd2);
    wr(A_CTRL, 32'h9);
    idle(6);
    rd(A_CTRL, 32'h8, 1'b1, "midrst_pre");
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    rd(A_CTRL,   32'd0, 1'b0, "midrst_ctrl");
    rd(A_PRESET, 32'd0, 1'b0, "midrst_preset");
    rd(A_COUNT,  32'd0, 1'b0, "midrst_count");
    idle(5);
    rd(A_COUNT,  32'd0, 1'b0, "midrst_quiet");

    idle(2);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
